// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multi-cycle MIPS-subset
// control sequencer (states, instruction classes, ALU ops, mux selects).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_LUI_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_ORI, C_LW, C_SW, C_BEQ, C_J, C_LUI, C_ILL
  } iclass_t;

  // ALU 2-bit operation encoding
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct (IR[5:0])
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;

  // alu_src_b selects
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // pc_src selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // reg_wsrc selects
  localparam logic [1:0] WSRC_ALUOUT = 2'b00;
  localparam logic [1:0] WSRC_MDR    = 2'b01;
  localparam logic [1:0] WSRC_LUI    = 2'b10;

endpackage

// File: rtl/mc_ctrl_dec.sv
// mc_ctrl_dec: combinational instruction classifier. Maps opcode/funct to an
// instruction class and, for R-type, the ALU operation to run in EXEC_R.
module mc_ctrl_dec import mc_ctrl_pkg::*; (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic [1:0] r_op
);

  // classify; anything not in the supported subset falls to C_ILL
  always_comb begin
    iclass = C_ILL;
    r_op   = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin iclass = C_R; r_op = ALU_ADD; end
          FN_SUBU: begin iclass = C_R; r_op = ALU_SUB; end
          FN_AND:  begin iclass = C_R; r_op = ALU_AND; end
          FN_OR:   begin iclass = C_R; r_op = ALU_OR;  end
          default: iclass = C_ILL;
        endcase
      end
      OP_ORI:  iclass = C_ORI;
      OP_LW:   iclass = C_LW;
      OP_SW:   iclass = C_SW;
      OP_BEQ:  iclass = C_BEQ;
      OP_J:    iclass = C_J;
      OP_LUI:  iclass = C_LUI;
      default: iclass = C_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS-subset datapath.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap illegal instructions into a HALT
// state held until reset; otherwise an illegal instruction retires as a NOP.
module mc_ctrl import mc_ctrl_pkg::*; #(
  parameter int ILLEGAL_OP_LOG = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       pc_we,
  output logic       ir_we,
  output logic       mem_we,
  output logic       mem_re,
  output logic       reg_we,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sign,
  output logic [1:0] pc_src,
  output logic       reg_dst,
  output logic [1:0] reg_wsrc,
  output logic       instr_done,
  output logic       illegal
);

  state_t  state, state_nxt;
  iclass_t iclass;
  logic [1:0] r_op;
  logic ill_dec, ill_q;

  mc_ctrl_dec u_dec (
    .opcode (opcode),
    .funct  (funct),
    .iclass (iclass),
    .r_op   (r_op)
  );

  assign ill_dec = (state == S_DECODE) && (iclass == C_ILL);

  // state register; async reset aborts any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  // remembers that an illegal instruction was decoded since reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ill_q <= 1'b0;
    else if (ill_dec) ill_q <= 1'b1;
  end

  // illegal shows in the decoding cycle itself, then optionally stays up
  always_comb begin
    illegal = ill_dec | ((ILLEGAL_OP_LOG != 0) & ill_q);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    if (state == S_HALT) illegal = 1'b1;
`endif
  end

  // next-state and Moore/Mealy strobes per state
  always_comb begin
    state_nxt  = state;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    reg_we     = 1'b0;
    alu_op     = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    ext_sign   = 1'b0;
    pc_src     = PCSRC_ALU;
    reg_dst    = 1'b0;
    reg_wsrc   = WSRC_ALUOUT;
    instr_done = 1'b0;
    case (state)
      S_INIT: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_re    = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_we     = mem_rdy;
        ir_we     = mem_rdy;
        if (mem_rdy) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut <= PC+4 + branch offset, used later by BRANCH
        alu_src_b = SRCB_BOFF;
        case (iclass)
          C_R:       state_nxt = S_EXEC_R;
          C_ORI:     state_nxt = S_EXEC_I;
          C_LW, C_SW: state_nxt = S_MEM_ADDR;
          C_BEQ:     state_nxt = S_BRANCH;
          C_J:       state_nxt = S_JUMP;
          C_LUI:     state_nxt = S_LUI_WB;
          default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_nxt = S_HALT;
`else
            state_nxt  = S_FETCH;
            instr_done = 1'b1;
`endif
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_op;
        state_nxt = S_WB_R;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OR;
        state_nxt = S_WB_I;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_sign  = 1'b1;
        state_nxt = (iclass == C_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_re = 1'b1;
        if (mem_rdy) state_nxt = S_WB_MEM;
      end
      S_MEM_WR: begin
        // held for the whole access; memory commits on the mem_rdy cycle
        mem_we     = 1'b1;
        instr_done = mem_rdy;
        if (mem_rdy) state_nxt = S_FETCH;
      end
      S_WB_R: begin
        reg_we = 1'b1; reg_dst = 1'b1; instr_done = 1'b1; state_nxt = S_FETCH;
      end
      S_WB_I: begin
        reg_we = 1'b1; instr_done = 1'b1; state_nxt = S_FETCH;
      end
      S_WB_MEM: begin
        reg_we = 1'b1; reg_wsrc = WSRC_MDR; instr_done = 1'b1; state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = PCSRC_ALUOUT;
        pc_we      = zero;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_JUMP: begin
        pc_we = 1'b1; pc_src = PCSRC_JUMP; instr_done = 1'b1; state_nxt = S_FETCH;
      end
      S_LUI_WB: begin
        reg_we = 1'b1; reg_wsrc = WSRC_LUI; instr_done = 1'b1; state_nxt = S_FETCH;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized scoreboard bench for mc_ctrl. The driver walks each
// instruction through the step list the ISA rules dictate and queues the
// expected output vector per cycle plus the expected instruction length; a
// monitor pops and compares on every falling edge and on every instr_done.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_rdy;
  logic       pc_we, ir_we, mem_we, mem_re, reg_we;
  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_sign;
  logic [1:0] pc_src;
  logic       reg_dst;
  logic [1:0] reg_wsrc;
  logic       instr_done, illegal;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_rdy(mem_rdy), .pc_we(pc_we), .ir_we(ir_we), .mem_we(mem_we),
    .mem_re(mem_re), .reg_we(reg_we), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_sign(ext_sign), .pc_src(pc_src),
    .reg_dst(reg_dst), .reg_wsrc(reg_wsrc), .instr_done(instr_done),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_we, ir_we, mem_we, mem_re, reg_we;
    logic [1:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       ext;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic [1:0] wsrc;
    logic       done, ill;
  } ov_t;

  ov_t act;
  assign act = {pc_we, ir_we, mem_we, mem_re, reg_we, alu_op, alu_src_a,
                alu_src_b, ext_sign, pc_src, reg_dst, reg_wsrc, instr_done, illegal};

  ov_t eq[$];
  int  lq[$];
  int  checks = 0;
  int  errors = 0;
  int  cnt = 0;
  bit  sticky = 1'b0;

  // instruction classes: 0 R, 1 ori, 2 lw, 3 sw, 4 beq, 5 j, 6 lui, 7 illegal
  function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: return (fn == 6'h21 || fn == 6'h23 || fn == 6'h24 || fn == 6'h25) ? 0 : 7;
      6'h0D: return 1;
      6'h23: return 2;
      6'h2B: return 3;
      6'h04: return 4;
      6'h02: return 5;
      6'h0F: return 6;
      default: return 7;
    endcase
  endfunction

  function automatic logic [1:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h23: return 2'b01;
      6'h24: return 2'b10;
      6'h25: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // zero-wait cycle count per class
  function automatic int base_len(input int c);
    case (c)
      0, 1, 3: return 4;
      2:       return 5;
      4, 5, 6: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic cyc(input ov_t e);
    e.ill = e.ill | sticky;
    eq.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst_n  = 1'b0;
    sticky = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_rdy = 1'($urandom); zero = 1'($urandom);
      cyc('0);
    end
    rst_n = 1'b1;
    cyc('0);  // INIT
  endtask

  // fw/mw: wait cycles in FETCH / memory state (<0 = random); zf: zero in BRANCH (<0 = random)
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input int zf);
    ov_t e;
    int  c, w, m;
    c = cls_of(op, fn);
    w = (fw < 0) ? int'($urandom_range(0, 2)) : fw;
    m = (mw < 0) ? int'($urandom_range(0, 2)) : mw;
    if (!(c == 2 || c == 3)) m = 0;
    opcode = op; funct = fn;
    for (int i = 0; i <= w; i++) begin
      mem_rdy = (i == w); zero = 1'($urandom);
      e = '0; e.mem_re = 1'b1; e.src_b = 2'b01; e.pc_we = mem_rdy; e.ir_we = mem_rdy;
      cyc(e);
    end
    mem_rdy = 1'($urandom); zero = 1'($urandom);
    e = '0; e.src_b = 2'b11;
    if (c == 7) begin
      e.ill = 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      cyc(e);
      for (int i = 0; i < 20; i++) begin
        mem_rdy = 1'($urandom); zero = 1'($urandom);
        e = '0; e.ill = 1'b1;
        cyc(e);
      end
`else
      e.done = 1'b1;
      lq.push_back(base_len(c) + w);
      cyc(e);
      sticky = 1'b1;
`endif
      return;
    end
    cyc(e);
    mem_rdy = 1'($urandom); zero = 1'($urandom);
    e = '0;
    case (c)
      0: begin
        e.src_a = 1'b1; e.alu_op = r_alu(fn); cyc(e);
        e = '0; e.reg_we = 1'b1; e.reg_dst = 1'b1; e.done = 1'b1;
      end
      1: begin
        e.src_a = 1'b1; e.src_b = 2'b10; e.alu_op = 2'b11; cyc(e);
        e = '0; e.reg_we = 1'b1; e.done = 1'b1;
      end
      2, 3: begin
        e.src_a = 1'b1; e.src_b = 2'b10; e.ext = 1'b1; cyc(e);
        for (int i = 0; i < m; i++) begin
          mem_rdy = 1'b0; zero = 1'($urandom);
          e = '0; if (c == 2) e.mem_re = 1'b1; else e.mem_we = 1'b1;
          cyc(e);
        end
        mem_rdy = 1'b1; zero = 1'($urandom);
        e = '0;
        if (c == 2) begin
          e.mem_re = 1'b1; cyc(e);
          mem_rdy = 1'($urandom); zero = 1'($urandom);
          e = '0; e.reg_we = 1'b1; e.wsrc = 2'b01; e.done = 1'b1;
        end else begin
          e.mem_we = 1'b1; e.done = 1'b1;
        end
      end
      4: begin
        zero = (zf < 0) ? 1'($urandom) : 1'(zf);
        e.src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_we = zero; e.done = 1'b1;
      end
      5: begin e.pc_we = 1'b1; e.pc_src = 2'b10; e.done = 1'b1; end
      default: begin e.reg_we = 1'b1; e.wsrc = 2'b10; e.done = 1'b1; end
    endcase
    lq.push_back(base_len(c) + w + m);
    cyc(e);
  endtask

  // monitor: per-cycle output vector and per-instruction length
  initial begin
    ov_t e;
    int  l;
    forever begin
      @(negedge clk);
      if (eq.size() > 0) begin
        e = eq.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL outputs t=%0t act=%h exp=%h", $time, act, e);
        end
      end
      if (!rst_n) cnt = -1;
      else        cnt++;
      if (rst_n === 1'b1 && instr_done === 1'b1) begin
        checks++;
        if (lq.size() == 0) begin
          errors++;
          $display("FAIL instr_done unexpected t=%0t", $time);
        end else begin
          l = lq.pop_front();
          if (cnt != l) begin
            errors++;
            $display("FAIL instr_len t=%0t act=%0d exp=%0d", $time, cnt, l);
          end
        end
        cnt = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ops[7];
    logic [5:0] fns[4];
    ov_t e;
    ops = '{6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h0F};
    fns = '{6'h21, 6'h23, 6'h24, 6'h25};
    rst_n = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_rdy = 1'b1;
    @(posedge clk); #1;
    do_reset(3);

    // directed cases
    run_instr(6'h00, 6'h23, 0, 0, -1);   // subu
    run_instr(6'h04, 6'h00, 0, 0, 1);    // beq taken
    run_instr(6'h04, 6'h00, 0, 0, 0);    // beq not taken
    run_instr(6'h23, 6'h00, 0, 2, -1);   // lw, 2 wait cycles -> 7
    run_instr(6'h2B, 6'h00, 0, 0, -1);   // sw
    run_instr(6'h0F, 6'h00, 1, 0, -1);   // lui with a fetch wait
    run_instr(6'h02, 6'h00, 0, 0, -1);   // j

    // sw aborted by reset during a MEM_WR wait
    opcode = 6'h2B; funct = 6'h00;
    mem_rdy = 1'b1; zero = 1'b0;
    e = '0; e.mem_re = 1'b1; e.src_b = 2'b01; e.pc_we = 1'b1; e.ir_we = 1'b1; cyc(e);
    e = '0; e.src_b = 2'b11; cyc(e);
    e = '0; e.src_a = 1'b1; e.src_b = 2'b10; e.ext = 1'b1; cyc(e);
    mem_rdy = 1'b0;
    e = '0; e.mem_we = 1'b1; cyc(e);
    do_reset(2);

    // randomized legal traffic
    for (int k = 0; k < 150; k++) begin
      int sel;
      sel = int'($urandom_range(0, 6));
      run_instr(ops[sel], (sel == 0) ? fns[$urandom_range(0, 3)] : 6'($urandom),
                -1, -1, -1);
    end

    // illegal instructions
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    run_instr(6'h3F, 6'h00, 0, 0, -1);
    do_reset(1);
    run_instr(6'h00, 6'h25, 0, 0, -1);
`else
    run_instr(6'h3F, 6'h00, 0, 0, -1);
    run_instr(6'h23, 6'h00, 0, 0, -1);   // next fetch follows, illegal stays up
    do_reset(1);
    run_instr(6'h00, 6'h00, 0, 0, -1);   // opcode 0 with unsupported funct
    run_instr(6'h0D, 6'h00, 0, 0, -1);
    do_reset(1);
    run_instr(6'h00, 6'h24, 0, 0, -1);   // illegal cleared by reset
`endif

    checks++;
    if (eq.size() != 0 || lq.size() != 0) begin
      errors++;
      $display("FAIL queues_drained act=%0d/%0d exp=0/0", eq.size(), lq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the MIPS-subset datapath: the initiator side of the 2-bit ALU interface. It issues `alu_op` plus operand selects each cycle and consumes the ALU `zero` flag for `beq`. It also sequences PC/IR/register-file/memory write enables across fetch, decode, execute, memory and writeback states. It sits between the instruction register and the shared single ALU, replacing the single-cycle controller.

## Interface
- `ILLEGAL_OP_LOG`, default 1: when 1, `illegal` is a sticky output; when 0, `illegal` is a one-cycle pulse.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26], stable from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU Zero flag, same cycle.
- `mem_rdy` in 1: memory completes the current access this cycle.
- `pc_we`, `ir_we`, `mem_we`, `mem_re`, `reg_we` out 1 each: write and read strobes.
- `alu_op` out 2: 00 add, 01 sub, 10 and, 11 or.
- `alu_src_a` out 1: 0 PC, 1 register A.
- `alu_src_b` out 2: 00 register B, 01 constant 4, 10 extended imm, 11 sext(imm)<<2.
- `ext_sign` out 1: 1 sign-extend, 0 zero-extend the immediate.
- `pc_src` out 2: 00 ALU result, 01 ALUOut, 10 jump target {PC[31:28], IR[25:0], 2'b00}.
- `reg_dst` out 1: 0 rt, 1 rd.
- `reg_wsrc` out 2: 00 ALUOut, 01 MDR, 10 {imm, 16'h0}.
- `instr_done` out 1: one-cycle pulse in the last cycle of each instruction.
- `illegal` out 1: undecodable instruction seen.

## Operation
- Supported instructions: addu, subu, and, or (R-type, opcode 0); ori, lw, sw, beq, lui, j. Any other opcode, or opcode 0 with another funct, is illegal.
- States and transitions:
  - INIT → FETCH, unconditional.
  - FETCH: `mem_re`, `ir_we`/`pc_we` only when `mem_rdy`; srcA PC, srcB 4, op add, `pc_src` 00. Stays in FETCH until `mem_rdy`, then → DECODE.
  - DECODE: srcA PC, srcB 11, op add; the branch target is latched into ALUOut by the datapath. Dispatches to: R → EXEC_R; ori → EXEC_I; lw/sw → MEM_ADDR; beq → BRANCH; j → JUMP; lui → LUI_WB; illegal → see Configuration.
  - EXEC_R: srcA reg, srcB 00, `alu_op` from funct (addu 00, subu 01, and 10, or 11) → WB_R.
  - EXEC_I: srcA reg, srcB 10, `ext_sign`=0, op or → WB_I.
  - MEM_ADDR: srcA reg, srcB 10, `ext_sign`=1, op add → MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD: `mem_re`; stays until `mem_rdy`, then → WB_MEM.
  - MEM_WR: `mem_we` held; on `mem_rdy` → FETCH with `instr_done`.
  - WB_R: `reg_we`, `reg_dst` 1, `reg_wsrc` 00. WB_I: `reg_we`, `reg_dst` 0, `reg_wsrc` 00. WB_MEM: `reg_we`, `reg_dst` 0, `reg_wsrc` 01. Each → FETCH with `instr_done`.
  - BRANCH: srcA reg, srcB 00, op sub, `pc_src` 01, `pc_we` = `zero` → FETCH with `instr_done`.
  - JUMP: `pc_we`, `pc_src` 10 → FETCH with `instr_done`.
  - LUI_WB: `reg_we`, `reg_dst` 0, `reg_wsrc` 10 → FETCH with `instr_done`.
- Outputs are combinational from the state register (plus `funct`, `opcode`, `zero`, `mem_rdy` where listed). Unlisted outputs are 0 and unlisted selects are 00.

## Timing
- Reset: state = INIT; every output 0, including `illegal`. Reset asserted mid-instruction aborts it immediately; no strobe fires after `rst_n` falls.
- Cycle counts with zero-wait memory: beq, j and lui take 3 cycles (INIT excluded); R-type, ori and sw take 4; lw takes 5. Each wait cycle (`mem_rdy`=0 in FETCH, MEM_RD or MEM_WR) adds exactly one cycle.
- `mem_we` is asserted for every MEM_WR cycle. The memory commits only on the `mem_rdy` cycle.
- `instr_done` is high exactly once per instruction, in the same cycle as its final strobe.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined: an illegal instruction in DECODE → HALT. HALT holds all strobes at 0 and `illegal` at 1 until reset; `instr_done` is not pulsed.
- `MC_CTRL_ILLEGAL_TRAP_EN` undefined: an illegal instruction is a NOP. DECODE → FETCH with `instr_done`=1, and `illegal` behaves per `ILLEGAL_OP_LOG`.

## Structure
- Package `mc_ctrl_pkg`: state enum, ALU op codes (matching the ALU's 2-bit encoding), opcode/funct constants, and the select encodings for `alu_src_b`, `pc_src` and `reg_wsrc`.
- One sub-module, `mc_ctrl_dec`: a combinational classifier from opcode/funct to an instruction-class enum and the R-type `alu_op`. The FSM lives in `mc_ctrl`.

## Test plan
- Reset release with `mem_rdy`=1 → INIT, then FETCH with `pc_we`=`ir_we`=1, `alu_op`=00, `alu_src_b`=01.
- subu (opcode 0, funct 0x23) → EXEC_R shows `alu_op`=01; WB_R shows `reg_we`=1, `reg_dst`=1; `instr_done` fires on the 4th cycle.
- beq twice, with `zero`=1 then `zero`=0 in BRANCH → `pc_we`=1 with `pc_src`=01 the first time, `pc_we`=0 the second; 3 cycles each.
- lw with `mem_rdy` low for 2 cycles in MEM_RD → 7 cycles total; `reg_wsrc`=01 in WB_MEM.
- sw with `mem_rdy` low 1 cycle, then reset asserted in the following MEM_WR cycle → `mem_we` drops to 0 immediately; state returns to INIT.
- Opcode 0x3F → with the macro defined, HALT with `illegal`=1 held for 20 cycles; without it, `instr_done` in DECODE and the next FETCH follows.
